// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the data-memory controller: word width and FSM states.
package dmem_ctrl_pkg;

    localparam int WORD_WIDTH  = 32;
    localparam int DMC_STATE_W = 2;

    typedef enum logic [DMC_STATE_W-1:0] {
        DMC_IDLE    = 2'd0,
        DMC_RD_REQ  = 2'd1,
        DMC_RD_WAIT = 2'd2,
        DMC_WR_REQ  = 2'd3
    } dmc_state_e;

endpackage

// File: rtl/dmem_ctrl_store_buffer.sv
// Circular store buffer with youngest-match load forwarding.
module store_buffer #(
    parameter int W        = 32,
    parameter int SB_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-3:0] push_addr,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-3:0] head_addr,
    output logic [W-1:0] head_data,
    input  logic [W-3:0] lk_addr,
    output logic         lk_hit,
    output logic [W-1:0] lk_data
);

    localparam int PW = $clog2(SB_DEPTH);
    localparam int CW = $clog2(SB_DEPTH + 1);

    logic [SB_DEPTH-1:0] valid_q, valid_d;
    logic [PW-1:0]       head_q, head_d;
    logic [PW-1:0]       tail_q, tail_d;
    logic [CW-1:0]       count_q, count_d;
    logic [W-3:0]        addr_q [SB_DEPTH];
    logic [W-3:0]        addr_d [SB_DEPTH];
    logic [W-1:0]        data_q [SB_DEPTH];
    logic [W-1:0]        data_d [SB_DEPTH];
    logic [PW-1:0]       idx;

    assign full      = (count_q == CW'(SB_DEPTH));
    assign empty     = (count_q == '0);
    assign head_addr = addr_q[head_q];
    assign head_data = data_q[head_q];

    // Next-state for pointers, count and entries; pop is applied before push so a
    // full-buffer push may reuse the slot being drained in the same cycle.
    always_comb begin
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PW'(1);
        end
        if (push) begin
            valid_d[tail_q] = 1'b1;
            addr_d[tail_q]  = push_addr;
            data_d[tail_q]  = push_data;
            tail_d          = tail_q + PW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    // Forwarding: scan from the youngest entry (tail-1) back toward head, first hit wins.
    always_comb begin
        lk_hit  = 1'b0;
        lk_data = '0;
        idx     = '0;
        for (int i = 1; i <= SB_DEPTH; i++) begin
            idx = tail_q - PW'(i);
            if (!lk_hit && valid_q[idx] && (addr_q[idx] == lk_addr)) begin
                lk_hit  = 1'b1;
                lk_data = data_q[idx];
            end
        end
    end

    // Control state: reset drops every buffered store.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry payload storage; only meaningful where the valid bit is set.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: store buffering, load forwarding, RAM sequencing, stall.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int W        = WORD_WIDTH,
    parameter int SB_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_en,
    input  logic [W-1:0] l_addr,
    output logic [W-1:0] l_data,
    input  logic         store_en,
    input  logic [W-1:0] s_addr,
    input  logic [W-1:0] s_data,
    output logic         mem_stall,
    output logic         ram_req,
    output logic         ram_we,
    output logic [W-1:0] ram_addr,
    output logic [W-1:0] ram_wdata,
    input  logic         ram_gnt,
    input  logic [W-1:0] ram_rdata,
    input  logic         ram_rvalid
);

    dmc_state_e   state_q, state_d;
    logic [W-1:0] l_data_q, l_data_d;
    logic         ram_req_q, ram_req_d;
    logic         ram_we_q, ram_we_d;
    logic [W-1:0] ram_addr_q, ram_addr_d;
    logic [W-1:0] ram_wdata_q, ram_wdata_d;

    logic         sb_push, sb_pop, sb_full, sb_empty, sb_hit;
    logic [W-3:0] sb_head_addr;
    logic [W-1:0] sb_head_data, sb_lk_data;
    logic         rd_done, load_done, miss_stall, full_stall, pair_stall;
    logic         unused_addr_bits;

    // Word addressing: the byte-offset bits of a store are irrelevant.
    assign unused_addr_bits = ^s_addr[1:0];

    store_buffer #(.W(W), .SB_DEPTH(SB_DEPTH)) u_sb (
        .clk       (clk),
        .rst       (rst),
        .push      (sb_push),
        .push_addr (s_addr[W-1:2]),
        .push_data (s_data),
        .pop       (sb_pop),
        .full      (sb_full),
        .empty     (sb_empty),
        .head_addr (sb_head_addr),
        .head_data (sb_head_data),
        .lk_addr   (l_addr[W-1:2]),
        .lk_hit    (sb_hit),
        .lk_data   (sb_lk_data)
    );

    // Stall sources and store acceptance; a load paired with a store goes first.
    always_comb begin
        rd_done    = (state_q == DMC_RD_WAIT) && ram_rvalid;
        sb_pop     = (state_q == DMC_WR_REQ) && ram_gnt;
        load_done  = load_en && (sb_hit || rd_done);
        miss_stall = load_en && !sb_hit && !rd_done;
        full_stall = store_en && sb_full && !sb_pop;
        pair_stall = store_en && load_en && !load_done;
        mem_stall  = rst && (miss_stall || full_stall || pair_stall);
        sb_push    = store_en && !full_stall && !pair_stall;
    end

    // FSM next state, RAM request registers and load-data capture.
    always_comb begin
        state_d     = state_q;
        l_data_d    = l_data_q;
        ram_req_d   = ram_req_q;
        ram_we_d    = ram_we_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        if (load_en && sb_hit) begin
            l_data_d = sb_lk_data;
        end
        unique case (state_q)
            DMC_IDLE: begin
                if (load_en && !sb_hit) begin
                    state_d    = DMC_RD_REQ;
                    ram_req_d  = 1'b1;
                    ram_we_d   = 1'b0;
                    ram_addr_d = l_addr;
                end else if (!sb_empty) begin
                    state_d     = DMC_WR_REQ;
                    ram_req_d   = 1'b1;
                    ram_we_d    = 1'b1;
                    ram_addr_d  = {sb_head_addr, 2'b00};
                    ram_wdata_d = sb_head_data;
                end
            end
            DMC_RD_REQ: begin
                if (ram_gnt) begin
                    state_d   = DMC_RD_WAIT;
                    ram_req_d = 1'b0;
                end
            end
            DMC_RD_WAIT: begin
                if (ram_rvalid) begin
                    state_d  = DMC_IDLE;
                    l_data_d = ram_rdata;
                end
            end
            DMC_WR_REQ: begin
                if (ram_gnt) begin
                    state_d   = DMC_IDLE;
                    ram_req_d = 1'b0;
                    ram_we_d  = 1'b0;
                end
            end
            default: state_d = DMC_IDLE;
        endcase
    end

    // Registered state and outputs; reset abandons any outstanding access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= DMC_IDLE;
            l_data_q    <= '0;
            ram_req_q   <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            l_data_q    <= l_data_d;
            ram_req_q   <= ram_req_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

    assign l_data    = l_data_q;
    assign ram_req   = ram_req_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory controller that sits directly downstream of the CPU's MEM-stage load/store port and drives a single-port, variable-latency data RAM. It absorbs stores into a small circular store buffer, so stores normally cost no cycles. Loads are served either by forwarding from that buffer or by a RAM read. It returns `mem_stall` to the hazard unit, which freezes the pipeline while a load miss or a full-buffer store is outstanding.

## Interface

Parameters:
- `W`, default `WORD_WIDTH` (32): data/address width.
- `SB_DEPTH`, default 2: store-buffer entries, power of two, ≥2.

Ports (clock and reset first):
- `clk`  in  1  — the single clock.
- `rst`  in  1  — reset, asynchronous, active-low.
- `load_en`  in  1  — CPU load request; held stable while `mem_stall`=1.
- `l_addr`  in  W  — load address (word-aligned, bits [1:0] ignored).
- `l_data`  out  W  — registered load data.
- `store_en`  in  1  — CPU store request; held while `mem_stall`=1.
- `s_addr`  in  W  — store address (bits [1:0] ignored).
- `s_data`  in  W  — store data, full word.
- `mem_stall`  out  1  — freeze pipeline (combinational).
- `ram_req`  out  1  — RAM request, registered.
- `ram_we`  out  1  — 1 = write, 0 = read.
- `ram_addr`  out  W  — RAM address.
- `ram_wdata`  out  W  — RAM write data.
- `ram_gnt`  in  1  — RAM accepts the request this cycle.
- `ram_rdata`  in  W  — read data.
- `ram_rvalid`  in  1  — `ram_rdata` valid; at most one read is outstanding.

## Operation

- The store buffer is circular, with head/tail pointers mod `SB_DEPTH` and a count from 0 to `SB_DEPTH`. Each entry holds {valid, addr[W-1:2], data}.
- Store accept:
  - If count < `SB_DEPTH`, the store is pushed at the cycle edge and `mem_stall` stays 0.
  - If the buffer is full but a pop occurs in the same cycle (WR_REQ with `ram_gnt`), the push is still accepted.
  - Otherwise `mem_stall`=1.
- Load lookup compares `l_addr[W-1:2]` against all valid entries; the youngest match wins.
  - On a hit: no RAM access, and `l_data` is loaded at the edge.
  - On a miss: the FSM issues a read.
- FSM states and transitions:
  - IDLE:
    - Load miss → RD_REQ.
    - Otherwise, buffer non-empty → WR_REQ, presenting the head entry.
    - Loads take priority over draining.
  - RD_REQ: `ram_req`=1, `ram_we`=0, `ram_addr`=`l_addr`. On `ram_gnt` → RD_WAIT.
  - RD_WAIT: on `ram_rvalid`, `l_data` ← `ram_rdata` and go to IDLE.
  - WR_REQ: `ram_req`=1, `ram_we`=1, head addr/data. On `ram_gnt`, pop and go to IDLE. The request is never withdrawn once raised.
- A load that arrives during WR_REQ stalls until the write is granted and is then handled from IDLE, so RAM order is write then read.
- `load_en` and `store_en` asserted together: the load is served first and the store stalls until the load completes.
- `mem_stall` is the OR of:
  - (`load_en` & miss & ~(RD_WAIT & `ram_rvalid`));
  - (`store_en` & full & ~pop);
  - (`store_en` & `load_en` & load not completing this cycle).
- `mem_stall` is forced to 0 while `rst`=0.

## Timing

- Reset (`rst`=0, asynchronous) clears:
  - all buffer entries invalid, pointers and count 0;
  - state IDLE;
  - `l_data`, `ram_req`, `ram_we`, `ram_addr`, `ram_wdata` all 0.
- Reset mid-operation drops buffered stores and any outstanding read. An `ram_rvalid` arriving after reset release is ignored in IDLE.
- Load hit: `load_en` at cycle t → `l_data` valid at t+1, no stall.
- Load miss:
  - `mem_stall`=1 from cycle t.
  - `ram_req` from t+1.
  - `mem_stall` drops in the `ram_rvalid` cycle, and `l_data` is valid the following cycle.
  - Minimum latency is 2 stall cycles with zero-wait `ram_gnt` and `ram_rvalid` one cycle after grant.
- Store to a non-full buffer: 0 stall cycles. Drain starts the cycle after IDLE sees a non-empty buffer.
- `l_data` holds its value until the next completed load.

## Structure

- `defines.v` gets `WORD_WIDTH` (already present), the FSM state encodings (`DMC_IDLE`, `DMC_RD_REQ`, `DMC_RD_WAIT`, `DMC_WR_REQ`), and a `DMC_STATE_W` width.
- Sub-module `store_buffer`:
  - contains push/pop, full/empty, head outputs, and the youngest-match forwarding lookup;
  - forwarding is implemented as a priority scan from tail-1 back to head.
- `dmem_ctrl` holds the FSM, the stall logic and the `l_data` register.

## Test plan

1. Store 0x100←0xDEADBEEF, next cycle load 0x100 → no stall; `l_data`=0xDEADBEEF at t+1; no RAM read issued.
2. Load 0x200 miss, `ram_gnt` immediate, `ram_rvalid` one cycle later with 0x12345678 → `mem_stall` high for 2 cycles; `l_data`=0x12345678; a single `ram_req` with `ram_we`=0.
3. `SB_DEPTH`=2, `ram_gnt` held low, stores to 0x10, 0x14, 0x18:
   - the third store sees `mem_stall`=1;
   - raise `ram_gnt` → write of 0x10 granted, and 0x18 is accepted in the same cycle;
   - RAM writes then follow in order 0x10, 0x14, 0x18.
4. Stores 0x40←1 then 0x40←2, then load 0x40 → `l_data`=2 (youngest entry wins), no stall.
5. Load miss 0x80 arriving while WR_REQ is waiting for grant with 3 cycles to `ram_gnt` → stall persists; RAM sees the write first, then the read of 0x80; the correct data is returned.
6. Assert `rst`=0 in RD_WAIT, release, then pulse `ram_rvalid` → all outputs 0 during reset; the stale `ram_rvalid` is ignored; state IDLE; buffer empty.
